// File: rtl/register_file_irq.sv
// rtl/register_file_irq.sv - register file with W1C status, interrupt mask and irq/ack handshake
//
// Register file placed between decode and execute: two write ports, NumReadPorts
// combinational read ports, and an interrupt block fed by the status register.
//   r0 : status. Bits [DW/2 +: NumIrq] read pending & mask; bits [NumIrq-1:0] read
//        busy_flags live; all other bits read 0. Writes are write-1-to-clear on pending.
//   r1 : interrupt mask, taken from bits [DW/2 +: NumIrq]; every r1 bit is stored.
//   r2..NumRegs-1 : general purpose.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a read of r1..rN that hits
// an address being written this cycle returns the write data (port 1 priority).
// When undefined, reads return the pre-edge register contents.
//
// Ports:
//   clk        rising-edge clock
//   _reset     asynchronous active-high reset
//   w_en       write enable per write port (2)
//   w_addr     write address per write port
//   w_data     write data per write port
//   r_addr     read address per read port
//   r_data     read data per read port (combinational)
//   int_flags  interrupt event levels, latched into pending every cycle
//   busy_flags live busy status, visible in r0
//   int_ack    acknowledge the interrupt currently reported on irq_id
//   irq        any pending & mask bit set
//   irq_id     lowest index of pending & mask; 0 when irq is low
module register_file_irq #(
  parameter int DataWidth    = 16,
  parameter int NumRegs      = 16,
  parameter int NumReadPorts = 2,
  parameter int NumIrq       = 8,
  localparam int AW = $clog2(NumRegs),
  localparam int IW = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
  input  logic                                   clk,
  input  logic                                   _reset,
  input  logic [1:0]                             w_en,
  input  logic [1:0][AW-1:0]                     w_addr,
  input  logic [1:0][DataWidth-1:0]              w_data,
  input  logic [NumReadPorts-1:0][AW-1:0]        r_addr,
  output logic [NumReadPorts-1:0][DataWidth-1:0] r_data,
  input  logic [NumIrq-1:0]                      int_flags,
  input  logic [NumIrq-1:0]                      busy_flags,
  input  logic                                   int_ack,
  output logic                                   irq,
  output logic [IW-1:0]                          irq_id
);

  localparam int Lo = DataWidth / 2;

  logic [DataWidth-1:0] regs [NumRegs];
  logic [NumIrq-1:0]    pending;
  logic [NumIrq-1:0]    mask;
  logic [NumIrq-1:0]    active;
  logic [NumIrq-1:0]    clr_w1c;
  logic [NumIrq-1:0]    clr_ack;
  logic [DataWidth-1:0] status;

  assign mask   = regs[1][Lo +: NumIrq];
  assign active = pending & mask;
  assign irq    = |active;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    irq_id = '0;
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (active[i]) irq_id = i[IW-1:0];
    end
  end

  // Clears from both write ports targeting r0 merge together.
  always_comb begin
    clr_w1c = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_en[p] && (w_addr[p] == '0)) clr_w1c = clr_w1c | w_data[p][Lo +: NumIrq];
    end
  end

  // An ack only means something while an interrupt is actually being reported.
  assign clr_ack = (int_ack && irq) ? (NumIrq'(1) << irq_id) : '0;

  always_comb begin
    status                = '0;
    status[Lo +: NumIrq]  = active;
    status[NumIrq-1:0]    = busy_flags;
  end

  // regs[0] is never written; r0 reads come from the status word instead.
  always_ff @(posedge clk or posedge _reset) begin
    if (_reset) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        if (w_en[1] && (w_addr[1] == AW'(i))) begin
          regs[i] <= w_data[1];
        end else if (w_en[0] && (w_addr[0] == AW'(i))) begin
          regs[i] <= w_data[0];
        end
      end
      // New events override clears arriving in the same cycle.
      pending <= (pending & ~clr_w1c & ~clr_ack) | int_flags;
    end
  end

  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      if (r_addr[p] == '0) begin
        r_data[p] = status;
      end else begin
        r_data[p] = regs[r_addr[p]];
`ifdef REGFILE_BYPASS_EN
        if (w_en[1] && (w_addr[1] == r_addr[p])) begin
          r_data[p] = w_data[1];
        end else if (w_en[0] && (w_addr[0] == r_addr[p])) begin
          r_data[p] = w_data[0];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_register_file_irq.sv
// tb/tb_register_file_irq.sv - directed self-checking bench for register_file_irq
module tb_register_file_irq;

  logic             clk;
  logic             _reset;
  logic [1:0]       w_en;
  logic [1:0][3:0]  w_addr;
  logic [1:0][15:0] w_data;
  logic [1:0][3:0]  r_addr;
  logic [1:0][15:0] r_data;
  logic [7:0]       int_flags;
  logic [7:0]       busy_flags;
  logic             int_ack;
  logic             irq;
  logic [2:0]       irq_id;

  int checks   = 0;
  int failures = 0;

  register_file_irq dut (
    .clk        (clk),
    ._reset     (_reset),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .int_flags  (int_flags),
    .busy_flags (busy_flags),
    .int_ack    (int_ack),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    w_en = 2'b01; w_addr[0] = a; w_data[0] = d;
    tick();
    w_en = 2'b00;
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    r_addr[0] = a;
    #1;
    d = r_data[0];
  endtask

  logic [15:0] v;

  initial begin
    _reset = 1'b1; w_en = 2'b00; w_addr = '0; w_data = '0; r_addr = '0;
    int_flags = 8'h00; busy_flags = 8'h00; int_ack = 1'b0;
    tick(); tick();
    _reset = 1'b0;
    #1;
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_irq_id", {29'b0, irq_id}, 32'd0);
    rd(4'd0, v); check("reset_r0", {16'b0, v}, 32'h0000);

    // 1: reset clears a written register
    wr(4'd5, 16'hBEEF);
    rd(4'd5, v); check("r5_written", {16'b0, v}, 32'hBEEF);
    @(negedge clk); _reset = 1'b1; #1;
    rd(4'd5, v); check("r5_async_reset", {16'b0, v}, 32'h0000);
    tick(); _reset = 1'b0; #1;
    check("reset_irq2", {31'b0, irq}, 32'd0);
    check("reset_irq_id2", {29'b0, irq_id}, 32'd0);

    // 2: dual write to same address, port 1 wins; neighbour untouched
    wr(4'd4, 16'h4444);
    w_en = 2'b11; w_addr[0] = 4'd3; w_data[0] = 16'h1111; w_addr[1] = 4'd3; w_data[1] = 16'h2222;
    tick(); w_en = 2'b00;
    r_addr[0] = 4'd3; r_addr[1] = 4'd4; #1;
    check("dual_r3", {16'b0, r_data[0]}, 32'h2222);
    check("dual_r4_port1", {16'b0, r_data[1]}, 32'h4444);

    // 3: interrupt with mask 0x0C, ack walks through ids 2 then 3
    busy_flags = 8'h05;
    wr(4'd1, 16'h0C00);
    rd(4'd1, v); check("r1_readback", {16'b0, v}, 32'h0C00);
    int_flags = 8'h0C; #1;
    check("irq_not_same_cycle", {31'b0, irq}, 32'd0);
    tick(); int_flags = 8'h00; #1;
    check("irq3_high", {31'b0, irq}, 32'd1);
    check("irq3_id2", {29'b0, irq_id}, 32'd2);
    rd(4'd0, v); check("irq3_r0", {16'b0, v}, 32'h0C05);
    int_ack = 1'b1; tick(); int_ack = 1'b0; #1;
    check("ack1_irq", {31'b0, irq}, 32'd1);
    check("ack1_id3", {29'b0, irq_id}, 32'd3);
    int_ack = 1'b1; tick(); int_ack = 1'b0; #1;
    check("ack2_irq_low", {31'b0, irq}, 32'd0);
    check("ack2_id0", {29'b0, irq_id}, 32'd0);
    rd(4'd0, v); check("ack2_r0", {16'b0, v}, 32'h0005);

    // 4: W1C race, set beats clear; then plain clear; then dual-port clear OR
    wr(4'd1, 16'hFF00);
    int_flags = 8'h01; tick(); int_flags = 8'h00; #1;
    rd(4'd0, v); check("w1c_pending_set", {16'b0, v}, 32'h0105);
    int_flags = 8'h01; wr(4'd0, 16'h0100); int_flags = 8'h00; #1;
    rd(4'd0, v); check("w1c_race_kept", {16'b0, v}, 32'h0105);
    check("w1c_race_irq", {31'b0, irq}, 32'd1);
    wr(4'd0, 16'h01FF);
    rd(4'd0, v); check("w1c_cleared", {16'b0, v}, 32'h0005);
    int_flags = 8'h03; tick(); int_flags = 8'h00; #1;
    w_en = 2'b11; w_addr[0] = 4'd0; w_data[0] = 16'h0100; w_addr[1] = 4'd0; w_data[1] = 16'h0200;
    tick(); w_en = 2'b00; #1;
    check("w1c_dual_irq", {31'b0, irq}, 32'd0);

    // 5: masked event latches, ack ignored while irq low, appears when unmasked
    wr(4'd1, 16'h0000);
    int_flags = 8'h80; tick(); int_flags = 8'h00; #1;
    check("mask_irq_low", {31'b0, irq}, 32'd0);
    rd(4'd0, v); check("mask_r0_hi", {24'b0, v[15:8]}, 32'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0; #1;
    wr(4'd1, 16'h8000);
    check("unmask_irq", {31'b0, irq}, 32'd1);
    check("unmask_id7", {29'b0, irq_id}, 32'd7);

    // 6: same-cycle write/read of r7
    w_en = 2'b01; w_addr[0] = 4'd7; w_data[0] = 16'hA5A5; r_addr[0] = 4'd7; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_r7", {16'b0, r_data[0]}, 32'hA5A5);
`else
    check("no_bypass_r7", {16'b0, r_data[0]}, 32'h0000);
`endif
    tick(); w_en = 2'b00; #1;
    check("r7_after_edge", {16'b0, r_data[0]}, 32'hA5A5);

    // Reset mid-operation with int_flags held high; event re-latches after release
    int_flags = 8'h10;
    @(negedge clk); _reset = 1'b1; #1;
    check("midreset_irq", {31'b0, irq}, 32'd0);
    rd(4'd7, v); check("midreset_r7", {16'b0, v}, 32'h0000);
    tick(); _reset = 1'b0;
    wr(4'd1, 16'hFF00);
    int_flags = 8'h00; #1;
    check("relatch_irq", {31'b0, irq}, 32'd1);
    check("relatch_id4", {29'b0, irq_id}, 32'd4);
    rd(4'd0, v); check("relatch_r0", {16'b0, v}, 32'h1005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
